// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider configuration requester.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package clk_div_pkg;

    // Width of a divider value on the control bus and on the divider port.
    localparam int CLK_DIV_W = 8;

    // Four-phase requester states:
    //   IDLE    - no transfer in flight, may launch
    //   REQ     - valid high, waiting for the synchronized ack to rise
    //   RELEASE - valid low, waiting for the synchronized ack to fall
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } clk_div_cfg_state_e;

endpackage : clk_div_pkg

// File: rtl/clk_div_cfg_sync.sv
// N-flop level synchronizer, all flops reset to 0.
// Latency: STAGES clk_i cycles from d_i to q_o.
// Backpressure: none (free-running level path).
//
// Ports:
//   clk_i  - destination-domain clock
//   rstn_i - async active-low reset
//   d_i    - asynchronous level input
//   q_o    - synchronized level output
module clk_div_cfg_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw level in at bit 0; the oldest sample leaves at the top.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : clk_div_cfg_sync

// File: rtl/clk_div_cfg_master.sv
// Turns single-cycle config writes into a four-phase valid/ack transfer to the clock divider.
// Latency: valid rises 1 cycle after acceptance; valid falls SYNC_STAGES+1 cycles after ack rises.
// Backpressure: one pending slot; cfg_ready_o drops only while that slot holds a write.
//
// Ports:
//   clk_i, rstn_i     - SoC clock, async active-low reset
//   cfg_valid_i/data  - write request from the control bus (accepted on valid && ready)
//   cfg_ready_o       - low while the pending slot is full
//   clk_div_data_o    - registered divider value, frozen for the whole transfer
//   clk_div_valid_o   - registered four-phase request level
//   clk_div_ack_i     - divider ack, asynchronous to clk_i
//   busy_o            - transfer in flight or write pending
//   done_o            - one-cycle pulse when a transfer completes
//   cur_div_o         - last value acknowledged by the divider
module clk_div_cfg_master
    import clk_div_pkg::*;
#(
    parameter logic [CLK_DIV_W-1:0] DIV_INIT    = '0,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_valid_i,
    input  logic [CLK_DIV_W-1:0] cfg_data_i,
    output logic                 cfg_ready_o,
    output logic [CLK_DIV_W-1:0] clk_div_data_o,
    output logic                 clk_div_valid_o,
    input  logic                 clk_div_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CLK_DIV_W-1:0] cur_div_o
);

    // The raw ack is used nowhere except as the synchronizer input.
    logic ack_s;

    clk_div_cfg_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (clk_div_ack_i),
        .q_o    (ack_s)
    );

    clk_div_cfg_state_e   state_q, state_d;
    logic                 valid_q, valid_d;
    logic [CLK_DIV_W-1:0] data_q, data_d;
    logic [CLK_DIV_W-1:0] cur_q, cur_d;
    logic                 done_q, done_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [CLK_DIV_W-1:0] pend_data_q, pend_data_d;

    logic accept;
    logic launch;

    always_comb begin
        accept = cfg_valid_i && !pend_vld_q;
        // A launch needs a source and a quiet ack; a stale ack holds us in IDLE.
        launch = (state_q == IDLE) && !ack_s && (pend_vld_q || accept);

        state_d     = state_q;
        valid_d     = valid_q;
        data_d      = data_q;
        cur_d       = cur_q;
        done_d      = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    // The slot is older than any write arriving now, so it goes first.
                    data_d  = pend_vld_q ? pend_data_q : cfg_data_i;
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    valid_d = 1'b0;
                    cur_d   = data_q;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Launching from the slot frees it.
        if (launch && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end
        // Any accepted write that was not itself launched this cycle is parked.
        // accept implies the slot was empty, so this never overwrites.
        if (accept && !launch) begin
            pend_vld_d  = 1'b1;
            pend_data_d = cfg_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            data_q      <= DIV_INIT;
            cur_q       <= DIV_INIT;
            done_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            cur_q       <= cur_d;
            done_q      <= done_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign cfg_ready_o     = !pend_vld_q;
    assign clk_div_data_o  = data_q;
    assign clk_div_valid_o = valid_q;
    assign busy_o          = (state_q != IDLE) || pend_vld_q;
    assign done_o          = done_q;
    assign cur_div_o       = cur_q;

endmodule : clk_div_cfg_master

// File: tb/tb_clk_div_cfg_master.sv
// Self-checking bench for clk_div_cfg_master: table-driven single transfers,
// directed multi-cycle corner cases and a randomized phase scored against a
// transaction-level model (queue of accepted writes) with a delayed-ack divider model.
module tb_clk_div_cfg_master;

    localparam int         SYNC     = 2;
    localparam logic [7:0] DIV_INIT = 8'h04;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready_o;
    logic [7:0] clk_div_data_o;
    logic       clk_div_valid_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] cur_div_o;

    logic ack_r = 1'b0;
    logic ack_force = 1'b0;
    logic ack_raw;
    assign ack_raw = ack_force | ack_r;

    always #5 clk = ~clk;

    clk_div_cfg_master #(
        .DIV_INIT    (DIV_INIT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .cfg_valid_i     (cfg_valid),
        .cfg_data_i      (cfg_data),
        .cfg_ready_o     (cfg_ready_o),
        .clk_div_data_o  (clk_div_data_o),
        .clk_div_valid_o (clk_div_valid_o),
        .clk_div_ack_i   (ack_raw),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cur_div_o       (cur_div_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: ack follows valid after ack_dly cycles, in both directions.
    int ack_dly = 4;
    int ack_cnt = 0;
    always @(posedge clk) begin
        if (clk_div_valid_o != ack_r) begin
            if (ack_cnt >= ack_dly - 1) begin
                ack_r   <= clk_div_valid_o;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model + protocol monitor ----------------
    logic [7:0] accq[$];
    logic [7:0] done_log[$];
    logic [7:0] inflight = DIV_INIT;
    bit         in_xfer = 0;
    logic       prev_valid = 0, prev_ack = 0, prev_done = 0;
    logic [7:0] prev_data = DIV_INIT;
    int         ack_hi_cyc = 0, ack_lo_cyc = 0, rise_cyc = 0;
    bit         have_hi = 0, have_lo = 0;
    int         n_acc = 0, n_done = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            accq.delete();
            in_xfer    = 0;
            prev_valid = 0;
            prev_ack   = 0;
            prev_done  = 0;
            prev_data  = DIV_INIT;
            have_hi    = 0;
            have_lo    = 0;
        end else begin
            if (ack_raw && !prev_ack) begin ack_hi_cyc = cyc; have_hi = 1; end
            if (!ack_raw && prev_ack) begin ack_lo_cyc = cyc; have_lo = 1; end

            if (clk_div_data_o != prev_data)
                check("data_change_only_at_launch", int'(clk_div_valid_o && !prev_valid), 1);

            if (clk_div_valid_o && !prev_valid) begin
                rise_cyc = cyc;
                check("rise_ack_low", int'(ack_raw), 0);
                if (have_lo) check("rise_ack_gap", int'((cyc - ack_lo_cyc) >= SYNC + 1), 1);
                check("rise_queue_depth", accq.size(), 1);
                if (accq.size() != 0) begin
                    check("launch_data", int'(clk_div_data_o), int'(accq[0]));
                    inflight = accq.pop_front();
                end
                in_xfer = 1;
            end

            if (!clk_div_valid_o && prev_valid) begin
                if (have_hi) check("fall_latency", cyc - ack_hi_cyc, SYNC + 1);
                check("cur_at_fall", int'(cur_div_o), int'(inflight));
            end

            if (done_o) begin
                check("done_single_cycle", int'(prev_done), 0);
                if (have_lo) check("done_latency", cyc - ack_lo_cyc, SYNC + 1);
                check("done_cur", int'(cur_div_o), int'(inflight));
                done_log.push_back(cur_div_o);
                in_xfer = 0;
                n_done++;
            end

            check("ready", int'(cfg_ready_o), int'(accq.size() == 0));
            check("busy", int'(busy_o), int'(in_xfer || accq.size() != 0));

            if (cfg_valid && cfg_ready_o) begin
                accq.push_back(cfg_data);
                n_acc++;
            end

            prev_valid = clk_div_valid_o;
            prev_ack   = ack_raw;
            prev_done  = done_o;
            prev_data  = clk_div_data_o;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int sel);
        case (sel)
            0:       return clk_div_valid_o;
            1:       return done_o;
            default: return busy_o;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int sel, input logic lvl, input int budget);
        bit hit = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (sig(sel) == lvl) begin
                hit = 1;
                break;
            end
        end
        check({"wait_", nm}, int'(hit), 1);
    endtask

    task automatic write(input logic [7:0] d, output bit acc);
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_data  = d;
        acc       = cfg_ready_o;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         dly;
        int         exp_hi;
        logic [7:0] exp_cur;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int t_rise, t_fall, t_done;
        int acc0, done0;

        // valid stays up for dly (ack rise) + SYNC + 1 (sync + register) cycles;
        // done follows valid fall by the same amount.
        tbl[0] = '{8'h05, 4, 4 + SYNC + 1, 8'h05};
        tbl[1] = '{8'hA5, 1, 1 + SYNC + 1, 8'hA5};
        tbl[2] = '{8'hFF, 3, 3 + SYNC + 1, 8'hFF};
        tbl[3] = '{8'h3C, 6, 6 + SYNC + 1, 8'h3C};

        // ---- reset, idle ----
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", int'(clk_div_valid_o), 0);
        check("rst_data", int'(clk_div_data_o), int'(DIV_INIT));
        check("rst_cur", int'(cur_div_o), int'(DIV_INIT));
        check("rst_ready", int'(cfg_ready_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);

        // ---- table-driven single writes ----
        for (int i = 0; i < 4; i++) begin
            ack_dly = tbl[i].dly;
            write(tbl[i].data, acc);
            check("tbl_accept", int'(acc), 1);
            check("tbl_launch_1cyc", int'(clk_div_valid_o), 1);
            check("tbl_data", int'(clk_div_data_o), int'(tbl[i].data));
            t_rise = cyc;
            wait_for("tbl_fall", 0, 1'b0, 40);
            t_fall = cyc;
            check("tbl_valid_high_time", t_fall - t_rise, tbl[i].exp_hi);
            wait_for("tbl_done", 1, 1'b1, 40);
            t_done = cyc;
            check("tbl_fall_to_done", t_done - t_fall, tbl[i].exp_hi);
            check("tbl_cur", int'(cur_div_o), int'(tbl[i].exp_cur));
            check("tbl_data_hold", int'(clk_div_data_o), int'(tbl[i].data));
            @(negedge clk);
            #1;
            check("tbl_done_cleared", int'(done_o), 0);
            check("tbl_idle_busy", int'(busy_o), 0);
        end

        // ---- back-to-back with a refused third write ----
        ack_dly = 4;
        done_log.delete();
        write(8'h03, acc);
        check("b2b_acc_03", int'(acc), 1);
        write(8'h07, acc);
        check("b2b_acc_07", int'(acc), 1);
        check("b2b_in_req", int'(clk_div_valid_o), 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h09;
        check("b2b_refuse_09", int'(cfg_ready_o), 0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        wait_for("b2b_done1", 1, 1'b1, 60);
        @(negedge clk);
        wait_for("b2b_done2", 1, 1'b1, 60);
        check("b2b_busy_after", int'(busy_o), 0);
        check("b2b_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            check("b2b_first", int'(done_log[0]), 8'h03);
            check("b2b_second", int'(done_log[1]), 8'h07);
        end

        // ---- stale ack held from reset ----
        ack_force = 1'b1;
        do_reset();
        repeat (6) @(posedge clk);
        write(8'h0A, acc);
        check("stale_accept", int'(acc), 1);
        check("stale_ready", int'(cfg_ready_o), 0);
        check("stale_busy", int'(busy_o), 1);
        repeat (5) @(posedge clk);
        #1;
        check("stale_valid_held", int'(clk_div_valid_o), 0);
        @(posedge clk);
        #1;
        ack_force = 1'b0;
        wait_for("stale_rise", 0, 1'b1, 20);
        check("stale_rise_latency", rise_cyc - ack_lo_cyc, SYNC + 1);
        check("stale_data", int'(clk_div_data_o), 8'h0A);
        wait_for("stale_done", 1, 1'b1, 60);
        check("stale_cur", int'(cur_div_o), 8'h0A);

        // ---- reset in REQ with the slot full ----
        ack_dly = 12;
        write(8'h20, acc);
        write(8'h21, acc);
        check("mr_slot_full", int'(cfg_ready_o), 0);
        check("mr_in_req", int'(clk_div_valid_o), 1);
        rstn = 1'b0;
        #1;
        check("mr_valid_async", int'(clk_div_valid_o), 0);
        check("mr_ready", int'(cfg_ready_o), 1);
        check("mr_busy", int'(busy_o), 0);
        check("mr_data", int'(clk_div_data_o), int'(DIV_INIT));
        check("mr_cur", int'(cur_div_o), int'(DIV_INIT));
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        ack_dly = 3;
        repeat (4) @(posedge clk);
        check("mr_ack_low", int'(ack_raw), 0);
        write(8'h11, acc);
        check("mr_accept", int'(acc), 1);
        wait_for("mr_done", 1, 1'b1, 40);
        check("mr_cur_11", int'(cur_div_o), 8'h11);

        // ---- randomized traffic vs. the transaction model ----
        acc0  = n_acc;
        done0 = n_done;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            if (c % 150 == 0) ack_dly = $urandom_range(1, 6);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_data  = 8'($urandom);
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        wait_for("rnd_drain", 2, 1'b0, 200);
        check("rnd_queue_empty", accq.size(), 0);
        check("rnd_all_completed", n_done - done0, n_acc - acc0);
        check("rnd_some_traffic", int'((n_acc - acc0) > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_clk_div_cfg_master
